// File: rtl/uart_tx_scheduler_pkg.sv
// rtl/uart_tx_scheduler_pkg.sv - shared types and helpers for the UART TX frame scheduler
package uart_tx_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    ARM,
    WAIT,
    GUARD,
    RETRY,
    ABORT
  } tx_sched_state_e;

  localparam logic [3:0] MIN_DATA_BITS = 4'd5;
  localparam logic [3:0] MAX_DATA_BITS = 4'd8;

  function automatic logic [3:0] clamp_data_bits(input logic [3:0] bits);
    if (bits < MIN_DATA_BITS) return MIN_DATA_BITS;
    else if (bits > MAX_DATA_BITS) return MAX_DATA_BITS;
    else return bits;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// rtl/uart_tx_scheduler_if.sv - FIFO and TX FSM/shift-register handshake bundle
interface uart_tx_scheduler_if #(
  parameter int DATA_W = 8
);
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;
  logic              fifo_pop;
  logic              fsm_done_tx;
  logic              fsm_error;
  logic              fsm_txen;
  logic              sr_load;
  logic [DATA_W-1:0] sr_data;

  modport master (
    input  fifo_empty, fifo_rdata, fsm_done_tx, fsm_error,
    output fifo_pop, fsm_txen, sr_load, sr_data
  );

  modport slave (
    output fifo_empty, fifo_rdata, fsm_done_tx, fsm_error,
    input  fifo_pop, fsm_txen, sr_load, sr_data
  );
endinterface

// File: rtl/uart_tick_counter.sv
// rtl/uart_tick_counter.sv - loadable down-counter stepped by baud ticks, with zero flag
module uart_tick_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         zero
);
  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else if (load) count <= load_val;
    else if (tick && (count != '0)) count <= count - W'(1);
  end

  assign zero = (count == '0);
endmodule

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - frame-level UART TX controller: fetch, load, arm, retry, guard
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int GUARD_W    = 8,
  parameter int RETRY_W    = 2,
  parameter int CNT_W      = 16,
  parameter int WDOG_TICKS = 16
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  input  logic               baud_tick,
  input  logic               tx_enable,
  input  logic [3:0]         cfg_data_bits,
  input  logic               cfg_parity_en,
  input  logic               cfg_stop2,
  input  logic [GUARD_W-1:0] cfg_guard_ticks,
  input  logic [RETRY_W-1:0] cfg_max_retry,
  uart_tx_scheduler_if.master tx_if,
  output logic [3:0]         lat_data_bits,
  output logic               lat_parity_en,
  output logic               lat_stop2,
  output logic               busy,
  output logic               frame_done,
  output logic               abort_irq,
  output logic [CNT_W-1:0]   frames_sent
);
  localparam int WDOG_W = $clog2(WDOG_TICKS + 1);

  tx_sched_state_e    state_q, state_d;
  logic [DATA_W-1:0]  hold_q;
  logic [RETRY_W-1:0] lat_max_retry_q, retry_q;
  logic               guard_load, guard_zero, wdog_load, wdog_zero;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    tx_if.fifo_pop = 1'b0;
    tx_if.fsm_txen = 1'b0;
    tx_if.sr_load  = 1'b0;
    frame_done     = 1'b0;
    abort_irq      = 1'b0;
    guard_load     = 1'b0;
    wdog_load      = 1'b0;
    case (state_q)
      IDLE: if (tx_enable && !tx_if.fifo_empty) begin
        tx_if.fifo_pop = 1'b1;
        state_d        = FETCH;
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        tx_if.sr_load = 1'b1;
        state_d       = ARM;
      end
      ARM: begin
        tx_if.fsm_txen = 1'b1;
        if (baud_tick) begin
          wdog_load = 1'b1;
          state_d   = WAIT;
        end
      end
      // Error wins over done when the FSM flags both on the same tick.
      WAIT: if (baud_tick) begin
        if (tx_if.fsm_error) state_d = RETRY;
        else if (tx_if.fsm_done_tx) begin
          frame_done = 1'b1;
          guard_load = 1'b1;
          state_d    = GUARD;
        end else if (wdog_zero) state_d = RETRY;
      end
      GUARD: if (guard_zero) state_d = IDLE;
      RETRY: state_d = (retry_q < lat_max_retry_q) ? LOAD : ABORT;
      ABORT: begin
        abort_irq = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      hold_q          <= '0;
      lat_data_bits   <= MAX_DATA_BITS;
      lat_parity_en   <= 1'b0;
      lat_stop2       <= 1'b0;
      lat_max_retry_q <= '0;
      retry_q         <= '0;
      frames_sent     <= '0;
    end else begin
      if (state_q == FETCH) begin
        hold_q          <= tx_if.fifo_rdata;
        lat_data_bits   <= clamp_data_bits(cfg_data_bits);
        lat_parity_en   <= cfg_parity_en;
        lat_stop2       <= cfg_stop2;
        lat_max_retry_q <= cfg_max_retry;
      end
      if (state_q == ABORT) begin
        hold_q  <= '0;
        retry_q <= '0;
      end
      if (frame_done) begin
        frames_sent <= frames_sent + CNT_W'(1);
        retry_q     <= '0;
      end
      if ((state_q == RETRY) && (state_d == LOAD)) retry_q <= retry_q + RETRY_W'(1);
    end
  end

  always_comb begin
    tx_if.sr_data = '0;
    for (int i = 0; i < DATA_W; i++)
      if (i < int'(lat_data_bits)) tx_if.sr_data[i] = hold_q[i];
  end

  assign busy = (state_q != IDLE);

  uart_tick_counter #(.W(GUARD_W)) u_guard_cnt (
    .clk      (PCLK),
    .rst_n    (PRESETn),
    .load     (guard_load),
    .load_val (cfg_guard_ticks),
    .tick     (baud_tick && (state_q == GUARD)),
    .zero     (guard_zero)
  );

  // Loaded one short so the zero flag is seen on the last allowed WAIT tick.
  uart_tick_counter #(.W(WDOG_W)) u_wdog_cnt (
    .clk      (PCLK),
    .rst_n    (PRESETn),
    .load     (wdog_load),
    .load_val (WDOG_W'(WDOG_TICKS - 1)),
    .tick     (baud_tick && (state_q == WAIT)),
    .zero     (wdog_zero)
  );
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - randomized scoreboard bench for uart_tx_scheduler
module tb_uart_tx_scheduler;
  localparam int K_LOAD = 0, K_DONE = 1, K_ABORT = 2;
  localparam int OC_OK = 0, OC_ERR = 1, OC_BOTH = 2, OC_SILENT = 3;

  typedef struct {
    int kind;
    int data;
    int bits;
    int par;
    int stop;
    bit after_silent;
  } ev_t;

  logic       PCLK = 1'b0;
  logic       PRESETn;
  logic       baud_tick;
  logic       tx_enable;
  logic [3:0] cfg_data_bits;
  logic       cfg_parity_en, cfg_stop2;
  logic [7:0] cfg_guard_ticks;
  logic [1:0] cfg_max_retry;
  logic [3:0] lat_data_bits;
  logic       lat_parity_en, lat_stop2, busy, frame_done, abort_irq;
  logic [15:0] frames_sent;

  uart_tx_scheduler_if #(.DATA_W(8)) tif ();

  uart_tx_scheduler dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .baud_tick(baud_tick), .tx_enable(tx_enable),
    .cfg_data_bits(cfg_data_bits), .cfg_parity_en(cfg_parity_en), .cfg_stop2(cfg_stop2),
    .cfg_guard_ticks(cfg_guard_ticks), .cfg_max_retry(cfg_max_retry), .tx_if(tif.master),
    .lat_data_bits(lat_data_bits), .lat_parity_en(lat_parity_en), .lat_stop2(lat_stop2),
    .busy(busy), .frame_done(frame_done), .abort_irq(abort_irq), .frames_sent(frames_sent)
  );

  always #5 PCLK = ~PCLK;

  ev_t exp_q[$];
  int  out_q[$];
  int  fifo_q[$];
  int  n_checks = 0, n_fail = 0;
  int  model_sent = 0, pop_count = 0, cyc = 0;
  bit  sb_en = 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: one LOAD per attempt, then DONE on first success or ABORT once retries run out.
  task automatic send(input int b, input int plan);
    int  bits, m, oc;
    bit  prev_sil;
    ev_t e;
    bits = (cfg_data_bits < 5) ? 5 : (cfg_data_bits > 8) ? 8 : int'(cfg_data_bits);
    m = int'(cfg_max_retry);
    prev_sil = 1'b0;
    for (int a = 0; a <= m; a++) begin
      oc = (plan >> (2 * a)) & 3;
      e = '{K_LOAD, b % (1 << bits), bits, int'(cfg_parity_en), int'(cfg_stop2), prev_sil};
      exp_q.push_back(e);
      out_q.push_back(oc);
      if (oc == OC_OK) begin
        e.kind = K_DONE;
        exp_q.push_back(e);
        break;
      end
      prev_sil = (oc == OC_SILENT);
      if (a == m) begin
        e.kind = K_ABORT;
        exp_q.push_back(e);
      end
    end
    fifo_q.push_back(b);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && fifo_q.size() == 0 && !busy) && n < 3000) begin
      @(posedge PCLK); #1; n++;
    end
    if (n >= 3000) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic wait_pop(input string name);
    int n, start;
    n = 0;
    start = pop_count;
    while (pop_count == start && n < 200) begin
      @(posedge PCLK); #1; n++;
    end
    if (n >= 200) chk({name, "_pop_timeout"}, 0, 1);
  endtask

  // FIFO model: read data appears the cycle after the pop strobe.
  initial begin
    bit pop_s;
    tif.fifo_empty = 1'b1;
    tif.fifo_rdata = 8'h00;
    forever begin
      @(negedge PCLK);
      pop_s = tif.fifo_pop;
      @(posedge PCLK); #1;
      if (pop_s) begin
        if (fifo_q.size() > 0) tif.fifo_rdata = 8'(fifo_q.pop_front());
        else chk("pop_from_empty_fifo", 1, 0);
      end
      tif.fifo_empty = (fifo_q.size() == 0);
    end
  end

  // TX FSM model: ticks every third cycle, answers each armed attempt after a random number of ticks.
  initial begin
    int phase, n, k, cur;
    bit tick, active, prev_txen;
    phase = 0; active = 0; prev_txen = 0; n = 0; k = 0; cur = 0;
    baud_tick = 0; tif.fsm_done_tx = 0; tif.fsm_error = 0;
    forever begin
      @(negedge PCLK);
      tick = (phase == 2);
      phase = (phase == 2) ? 0 : phase + 1;
      tif.fsm_done_tx = 0;
      tif.fsm_error = 0;
      if (tif.fsm_txen && !prev_txen) begin
        if (out_q.size() > 0) begin
          cur = out_q.pop_front(); active = 1; n = 0; k = $urandom_range(2, 10);
        end else begin
          active = 0;
          if (sb_en) chk("unexpected_txen", 1, 0);
        end
      end
      prev_txen = tif.fsm_txen;
      if (active && tick) begin
        n++;
        if (n == k) begin
          active = 0;
          tif.fsm_done_tx = (cur == OC_OK || cur == OC_BOTH);
          tif.fsm_error = (cur == OC_ERR || cur == OC_BOTH);
        end
      end
      baud_tick = tick;
    end
  end

  // Monitor: pops the scoreboard on every DUT-presented event.
  initial begin
    int gcount, exp_guard, pop_cyc, wait_ticks;
    bit gcounting, lat_pending, prev_txen;
    ev_t e;
    gcount = 0; exp_guard = 0; pop_cyc = 0; wait_ticks = 0;
    gcounting = 0; lat_pending = 0; prev_txen = 0;
    forever begin
      @(negedge PCLK); #1;
      cyc++;
      if (PRESETn && sb_en) begin
        if (tif.fifo_pop) begin
          pop_count++;
          chk("pop_while_disabled", int'(tx_enable), 1);
          if (gcounting) chk("guard_ticks_before_pop_ok", int'(gcount >= exp_guard), 1);
          gcounting = 0; lat_pending = 1; pop_cyc = cyc;
        end else if (gcounting && baud_tick) gcount++;
        if (tif.fsm_txen && !prev_txen && lat_pending) begin
          chk("pop_to_txen_latency", cyc - pop_cyc, 3);
          lat_pending = 0;
        end
        if (tif.fsm_txen) wait_ticks = 0;
        else if (baud_tick) wait_ticks++;
        if (tif.sr_load) begin
          if (exp_q.size() == 0) chk("unexpected_sr_load", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("event_kind_load", K_LOAD, e.kind);
            chk("sr_data", int'(tif.sr_data), e.data);
            chk("lat_data_bits", int'(lat_data_bits), e.bits);
            chk("lat_parity_en", int'(lat_parity_en), e.par);
            chk("lat_stop2", int'(lat_stop2), e.stop);
            chk("frames_sent_at_load", int'(frames_sent), model_sent % 65536);
            if (e.after_silent) chk("watchdog_wait_ticks", wait_ticks, 16);
          end
        end
        if (frame_done) begin
          if (exp_q.size() == 0) chk("unexpected_frame_done", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("event_kind_done", K_DONE, e.kind);
          end
          model_sent++;
          gcounting = 1; gcount = 0; exp_guard = int'(cfg_guard_ticks);
        end
        if (abort_irq) begin
          if (exp_q.size() == 0) chk("unexpected_abort", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("event_kind_abort", K_ABORT, e.kind);
          end
          gcounting = 0;
        end
      end
      prev_txen = tif.fsm_txen;
    end
  end

  task automatic set_cfg(input int bits, input int par, input int stop, input int guard, input int mr);
    cfg_data_bits = 4'(bits);
    cfg_parity_en = 1'(par);
    cfg_stop2 = 1'(stop);
    cfg_guard_ticks = 8'(guard);
    cfg_max_retry = 2'(mr);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_fifo_pop"}, int'(tif.fifo_pop), 0);
    chk({name, "_txen"}, int'(tif.fsm_txen), 0);
    chk({name, "_sr_load"}, int'(tif.sr_load), 0);
    chk({name, "_sr_data"}, int'(tif.sr_data), 0);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_frame_done"}, int'(frame_done), 0);
    chk({name, "_abort_irq"}, int'(abort_irq), 0);
    chk({name, "_frames_sent"}, int'(frames_sent), 0);
    chk({name, "_lat_data_bits"}, int'(lat_data_bits), 8);
    chk({name, "_lat_parity"}, int'(lat_parity_en), 0);
    chk({name, "_lat_stop2"}, int'(lat_stop2), 0);
  endtask

  initial begin
    int sent_before, pops_before, n;
    PRESETn = 1'b0;
    tx_enable = 1'b0;
    set_cfg(8, 0, 0, 0, 0);
    #12;
    check_reset_outputs("reset");
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    tx_enable = 1'b1;

    // 8N1, single byte, success
    send(8'hA5, OC_OK);
    wait_idle("t1");
    chk("t1_frames_sent", int'(frames_sent), 1);
    chk("t1_pop_count", pop_count, 1);

    // data-bit masking and clamping
    set_cfg(5, 1, 1, 0, 0);
    send(8'hFF, OC_OK);
    wait_idle("t2a");
    set_cfg(3, 0, 1, 0, 0);
    send(8'h5A, OC_OK);
    wait_idle("t2b");
    set_cfg(12, 1, 0, 0, 0);
    send(8'hC3, OC_OK);
    wait_idle("t2c");

    // retries exhausted
    sent_before = int'(frames_sent);
    pops_before = pop_count;
    set_cfg(8, 0, 0, 0, 2);
    send(8'h3C, OC_ERR | (OC_ERR << 2) | (OC_ERR << 4));
    wait_idle("t3");
    chk("t3_frames_unchanged", int'(frames_sent), sent_before);
    chk("t3_single_pop", pop_count - pops_before, 1);

    // guard between two queued frames
    set_cfg(7, 0, 0, 4, 0);
    send(8'h11, OC_OK);
    send(8'h22, OC_OK);
    wait_idle("t4");

    // done+error together, then watchdog silence
    set_cfg(8, 1, 0, 0, 1);
    send(8'h81, OC_BOTH | (OC_OK << 2));
    wait_idle("t5a");
    send(8'h42, OC_SILENT | (OC_OK << 2));
    wait_idle("t5b");

    // tx_enable dropped mid-frame
    set_cfg(6, 0, 1, 2, 0);
    send(8'h99, OC_OK);
    wait_pop("t6");
    tx_enable = 1'b0;
    pops_before = pop_count;
    send(8'h66, OC_OK);
    n = 0;
    while (busy && n < 1000) begin @(posedge PCLK); #1; n++; end
    repeat (20) @(posedge PCLK);
    #1;
    chk("t6_first_frame_finished", model_sent, int'(frames_sent));
    chk("t6_no_pop_when_disabled", pop_count, pops_before);
    chk("t6_byte_still_queued", fifo_q.size(), 1);
    tx_enable = 1'b1;
    wait_idle("t6b");

    // randomized frames; cfg scrambled after each fetch must not matter
    for (int f = 0; f < 20; f++) begin
      set_cfg($urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 3), $urandom_range(0, 3));
      send($urandom_range(0, 255), $urandom_range(0, 255));
      wait_pop("rnd");
      repeat (2) @(posedge PCLK);
      #1;
      cfg_data_bits = 4'($urandom_range(0, 15));
      cfg_parity_en = 1'($urandom_range(0, 1));
      cfg_stop2 = 1'($urandom_range(0, 1));
      cfg_max_retry = 2'($urandom_range(0, 3));
      wait_idle("rnd");
    end
    chk("final_frames_sent", int'(frames_sent), model_sent);
    chk("final_outcomes_consumed", out_q.size(), 0);

    // reset while waiting on the FSM
    set_cfg(8, 0, 0, 0, 3);
    send(8'h5D, 8'hFF);
    n = 0;
    while (!tif.fsm_txen && n < 200) begin @(posedge PCLK); #1; n++; end
    while (tif.fsm_txen && n < 400) begin @(posedge PCLK); #1; n++; end
    if (n >= 400) chk("t7_reach_wait", 0, 1);
    repeat (3) @(posedge PCLK);
    #1;
    sb_en = 1'b0;
    PRESETn = 1'b0;
    @(negedge PCLK);
    check_reset_outputs("reset_mid_wait");
    exp_q.delete();
    out_q.delete();
    fifo_q.delete();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
